// File: rtl/swan_bus_if.sv
// Signal bundle between the cartridge-bus cycle generator, its command source and the cartridge pins.
// master = the cycle generator, slave = the command source / cartridge side.
interface swan_bus_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_write;
  logic                  cmd_io;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;
  logic                  n_sel;
  logic                  n_oe;
  logic                  n_we;
  logic                  n_io;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_oe;
  logic [DATA_WIDTH-1:0] data_in;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, cmd_write, cmd_io, data_in,
    output cmd_ready, rsp_valid, rsp_data, busy,
    output n_sel, n_oe, n_we, n_io, addr, data_out, data_oe
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, cmd_write, cmd_io, data_in,
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  n_sel, n_oe, n_we, n_io, addr, data_out, data_oe
  );
endinterface

// File: rtl/swan_bus_driver.sv
// WonderSwan cartridge-bus cycle generator: queued memory/IO read/write commands are expanded
// into SETUP/STROBE/HOLD bus cycles; read data comes back on a one-cycle response strobe.
module swan_bus_driver #(
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  swan_bus_if.master  bus
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ENTRY_W   = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int MAX_SS    = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_PHASE = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
  localparam int PH_W      = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  localparam logic [PH_W-1:0] SETUP_LOAD  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] STROBE_LOAD = PH_W'(STROBE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LOAD   = PH_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  fifo_empty, fifo_full, push, pop;

  state_t                state_reg, state_next;
  logic [PH_W-1:0]       phase_reg, phase_next;
  logic                  capture;

  logic [ADDR_WIDTH-1:0] cur_addr_reg;
  logic [DATA_WIDTH-1:0] cur_data_reg;
  logic                  cur_write_reg, cur_io_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;

  // Ready looks only at the registered count, so a full FIFO refuses a push even on a pop edge.
  assign fifo_empty    = (count_reg == '0);
  assign fifo_full     = (count_reg == CNT_W'(FIFO_DEPTH));
  assign bus.cmd_ready = !rst && !fifo_full;
  assign push          = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.cmd_io, bus.cmd_write, bus.cmd_data, bus.cmd_addr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      phase_reg <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SETUP;
          phase_next = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (phase_reg == '0) begin
          state_next = STROBE;
          phase_next = STROBE_LOAD;
        end else begin
          phase_next = phase_reg - PH_W'(1);
        end
      end
      STROBE: begin
        if (phase_reg == '0) begin
          state_next = HOLD;
          phase_next = HOLD_LOAD;
          capture    = 1'b1;
        end else begin
          phase_next = phase_reg - PH_W'(1);
        end
      end
      HOLD: begin
        // Chaining straight into SETUP keeps nSel low between back-to-back cycles.
        if (phase_reg == '0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = SETUP;
            phase_next = SETUP_LOAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          phase_next = phase_reg - PH_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr_reg  <= '0;
      cur_data_reg  <= '0;
      cur_write_reg <= 1'b0;
      cur_io_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      if (pop) begin
        {cur_io_reg, cur_write_reg, cur_data_reg, cur_addr_reg} <= fifo_mem[rd_ptr_reg];
      end
      rsp_valid_reg <= capture && !cur_write_reg;
      if (capture && !cur_write_reg) begin
        rsp_data_reg <= bus.data_in;
      end
    end
  end

  // Pin outputs decode from registered state only, so reset releases strobes asynchronously.
  assign bus.n_sel     = (state_reg == IDLE);
  assign bus.n_oe      = !((state_reg == STROBE) && !cur_write_reg);
  assign bus.n_we      = !((state_reg == STROBE) && cur_write_reg);
  assign bus.n_io      = (state_reg == IDLE) || !cur_io_reg;
  assign bus.addr      = cur_addr_reg;
  assign bus.data_out  = cur_data_reg;
  assign bus.data_oe   = (state_reg != IDLE) && cur_write_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.busy      = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_swan_bus_driver.sv
// Bench for swan_bus_driver: a default instance (1/2/1, 20-bit) and a 2/3/2, 24-bit instance,
// checked every cycle against a command-queue/timeline model plus directed literal expectations.
module tb_swan_bus_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  swan_bus_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) bus_a ();
  swan_bus_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) bus_b ();

  swan_bus_driver #(
    .ADDR_WIDTH(20), .DATA_WIDTH(16), .SETUP_CYCLES(1), .STROBE_CYCLES(2),
    .HOLD_CYCLES(1), .FIFO_DEPTH(4)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  swan_bus_driver #(
    .ADDR_WIDTH(24), .DATA_WIDTH(16), .SETUP_CYCLES(2), .STROBE_CYCLES(3),
    .HOLD_CYCLES(2), .FIFO_DEPTH(4)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        w;
    logic        io;
  } cmd_t;

  logic cv [2];
  cmd_t cmd_in [2];

  assign bus_a.cmd_valid = cv[0];
  assign bus_a.cmd_addr  = cmd_in[0].addr[19:0];
  assign bus_a.cmd_data  = cmd_in[0].data;
  assign bus_a.cmd_write = cmd_in[0].w;
  assign bus_a.cmd_io    = cmd_in[0].io;
  assign bus_b.cmd_valid = cv[1];
  assign bus_b.cmd_addr  = cmd_in[1].addr;
  assign bus_b.cmd_data  = cmd_in[1].data;
  assign bus_b.cmd_write = cmd_in[1].w;
  assign bus_b.cmd_io    = cmd_in[1].io;

  // The "cartridge" returns address XOR 0x5AAA on the data bus.
  assign bus_a.data_in = bus_a.addr[15:0] ^ 16'h5AAA;
  assign bus_b.data_in = bus_b.addr[15:0] ^ 16'h5AAA;

  logic        o_ready [2], o_rv [2], o_busy [2], o_nsel [2], o_noe [2], o_nwe [2], o_nio [2], o_doe [2];
  logic [15:0] o_rd [2], o_dout [2];
  logic [23:0] o_addr [2];

  assign o_ready[0] = bus_a.cmd_ready;  assign o_ready[1] = bus_b.cmd_ready;
  assign o_rv[0]    = bus_a.rsp_valid;  assign o_rv[1]    = bus_b.rsp_valid;
  assign o_rd[0]    = bus_a.rsp_data;   assign o_rd[1]    = bus_b.rsp_data;
  assign o_busy[0]  = bus_a.busy;       assign o_busy[1]  = bus_b.busy;
  assign o_nsel[0]  = bus_a.n_sel;      assign o_nsel[1]  = bus_b.n_sel;
  assign o_noe[0]   = bus_a.n_oe;       assign o_noe[1]   = bus_b.n_oe;
  assign o_nwe[0]   = bus_a.n_we;       assign o_nwe[1]   = bus_b.n_we;
  assign o_nio[0]   = bus_a.n_io;       assign o_nio[1]   = bus_b.n_io;
  assign o_doe[0]   = bus_a.data_oe;    assign o_doe[1]   = bus_b.data_oe;
  assign o_dout[0]  = bus_a.data_out;   assign o_dout[1]  = bus_b.data_out;
  assign o_addr[0]  = {4'h0, bus_a.addr};
  assign o_addr[1]  = bus_b.addr;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t actual=0x%0h required=0x%0h", name, inst, $time, act, exp);
    end
  endtask

  function automatic cmd_t mkc(input logic [23:0] a, input logic [15:0] d, input logic w, input logic io);
    mkc = '{addr: a, data: d, w: w, io: io};
  endfunction

  // ---------------- model: queue of pending commands + offset within the running bus cycle
  int          ps [2] = '{1, 2};
  int          pt [2] = '{2, 3};
  int          ph [2] = '{1, 2};
  cmd_t        mbuf [2][16];
  int          mhead [2], mcount [2], mk [2];
  bit          mact [2];
  cmd_t        mcur [2];
  logic        exp_rv [2];
  logic [15:0] exp_rd [2];
  int          m_len;
  bit          m_last, m_accept, m_pop;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; mcount[i] = 0; mk[i] = 0; mact[i] = 1'b0;
      mcur[i] = '0; exp_rv[i] = 1'b0; exp_rd[i] = 16'h0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        for (int i = 0; i < 2; i++) begin
          m_len    = ps[i] + pt[i] + ph[i];
          m_last   = mact[i] && (mk[i] == m_len - 1);
          m_accept = cv[i] && (mcount[i] < 4);
          m_pop    = (mcount[i] > 0) && (!mact[i] || m_last);
          if (mact[i] && (mk[i] == ps[i] + pt[i] - 1) && !mcur[i].w) begin
            exp_rv[i] = 1'b1;
            exp_rd[i] = mcur[i].addr[15:0] ^ 16'h5AAA;
          end else begin
            exp_rv[i] = 1'b0;
          end
          if (m_pop) begin
            mcur[i]  = mbuf[i][mhead[i]];
            mhead[i] = (mhead[i] + 1) % 16;
            mcount[i]--;
            mact[i]  = 1'b1;
            mk[i]    = 0;
          end else if (m_last) begin
            mact[i] = 1'b0;
          end else if (mact[i]) begin
            mk[i]++;
          end
          if (m_accept) begin
            mbuf[i][(mhead[i] + mcount[i]) % 16] = cmd_in[i];
            mcount[i]++;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and event bookkeeping
  int          cyc = 0;
  bit          c_st, c_strobe;
  bit          prev_nsel [2] = '{1'b1, 1'b1};
  bit          prev_strobe [2] = '{1'b0, 1'b0};
  int          nsel_fall_cyc [2], nsel_rise_cyc [2], strobe_fall_cyc [2], strobe_rise_cyc [2];
  int          nsel_falls [2], nsel_low [2], noe_low [2], nwe_low [2], nio_low [2], doe_high [2], rsp_cnt [2];
  int          sfall_a [$];
  logic [15:0] rlog_a [$], rlog_b [$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        c_st = mact[i] && (mk[i] >= ps[i]) && (mk[i] < ps[i] + pt[i]);
        check("n_sel", i, o_nsel[i], !mact[i]);
        check("n_oe", i, o_noe[i], !(c_st && !mcur[i].w));
        check("n_we", i, o_nwe[i], !(c_st && mcur[i].w));
        check("n_io", i, o_nio[i], !(mact[i] && mcur[i].io));
        check("addr", i, o_addr[i], mcur[i].addr);
        check("data_oe", i, o_doe[i], mact[i] && mcur[i].w);
        if (mact[i] && mcur[i].w) check("data_out", i, o_dout[i], mcur[i].data);
        check("rsp_valid", i, o_rv[i], exp_rv[i]);
        check("rsp_data", i, o_rd[i], exp_rd[i]);
        check("busy", i, o_busy[i], mact[i] || (mcount[i] > 0));
        check("cmd_ready", i, o_ready[i], !rst && (mcount[i] < 4));

        c_strobe = !o_noe[i] || !o_nwe[i];
        if (prev_nsel[i] && !o_nsel[i]) begin
          nsel_fall_cyc[i] = cyc;
          nsel_falls[i]++;
        end
        if (!prev_nsel[i] && o_nsel[i]) nsel_rise_cyc[i] = cyc;
        if (c_strobe && !prev_strobe[i]) begin
          strobe_fall_cyc[i] = cyc;
          if (i == 0) sfall_a.push_back(cyc);
        end
        if (!c_strobe && prev_strobe[i]) strobe_rise_cyc[i] = cyc;
        if (!o_nsel[i]) nsel_low[i]++;
        if (!o_noe[i]) noe_low[i]++;
        if (!o_nwe[i]) nwe_low[i]++;
        if (!o_nio[i]) nio_low[i]++;
        if (o_doe[i]) doe_high[i]++;
        if (o_rv[i]) begin
          rsp_cnt[i]++;
          if (i == 0) rlog_a.push_back(o_rd[i]);
          else        rlog_b.push_back(o_rd[i]);
        end
        prev_nsel[i]   = o_nsel[i];
        prev_strobe[i] = c_strobe;
      end
    end
  end

  // ---------------- stimulus helpers (entered and left at posedge+1)
  task automatic send(input int i, input cmd_t c, output int stalls);
    bit r, ok;
    stalls = 0;
    ok = 1'b0;
    cv[i] = 1'b1;
    cmd_in[i] = c;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      r = o_ready[i];
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    cv[i] = 1'b0;
    if (!ok) check("send_timeout", i, 0, 1);
    $display("send inst=%0d addr=0x%06h data=0x%04h w=%0d io=%0d stalls=%0d", i, c.addr, c.data, c.w, c.io, stalls);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (!o_busy[0] && !o_busy[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int st, s0, s1, s2, s3, s4;

  initial begin
    rst = 1'b1;
    cv[0] = 1'b0; cv[1] = 1'b0;
    cmd_in[0] = '0; cmd_in[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_n_sel", 0, o_nsel[0], 1);
    check("rst_n_io", 0, o_nio[0], 1);
    check("rst_addr", 0, o_addr[0], 0);
    check("rst_data_out", 0, o_dout[0], 0);
    check("rst_rsp_data", 0, o_rd[0], 0);
    check("rst_cmd_ready", 0, o_ready[0], 0);
    check("rst_busy", 1, o_busy[1], 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 0, o_ready[0], 1);
    @(posedge clk);
    #1;

    // T1: memory read 0xFFF0, cartridge returns 0xA55A
    s0 = noe_low[0]; s1 = rsp_cnt[0]; s2 = nio_low[0];
    send(0, mkc(24'h0FFF0, 16'h0000, 1'b0, 1'b0), st);
    @(negedge clk); check("t1_e0_n_sel", 0, o_nsel[0], 1);
    @(negedge clk); check("t1_e1_n_sel", 0, o_nsel[0], 0); check("t1_e1_n_oe", 0, o_noe[0], 1);
    @(negedge clk); check("t1_e2_n_oe", 0, o_noe[0], 0);
    @(negedge clk); check("t1_e3_n_oe", 0, o_noe[0], 0);
    @(negedge clk); check("t1_e4_n_oe", 0, o_noe[0], 1); check("t1_e4_rsp_valid", 0, o_rv[0], 1);
    check("t1_e4_rsp_data", 0, o_rd[0], 16'hA55A);
    @(negedge clk); check("t1_e5_n_sel", 0, o_nsel[0], 1); check("t1_e5_rsp_valid", 0, o_rv[0], 0);
    wait_idle();
    check("t1_setup_len", 0, strobe_fall_cyc[0] - nsel_fall_cyc[0], 1);
    check("t1_strobe_len", 0, strobe_rise_cyc[0] - strobe_fall_cyc[0], 2);
    check("t1_hold_len", 0, nsel_rise_cyc[0] - strobe_rise_cyc[0], 1);
    check("t1_noe_cycles", 0, noe_low[0] - s0, 2);
    check("t1_rsp_count", 0, rsp_cnt[0] - s1, 1);
    check("t1_nio_cycles", 0, nio_low[0] - s2, 0);

    // T2: IO write 0x000E1 <- 0x0002
    s0 = nwe_low[0]; s1 = rsp_cnt[0]; s2 = nio_low[0]; s3 = doe_high[0];
    send(0, mkc(24'h000E1, 16'h0002, 1'b1, 1'b1), st);
    wait_idle();
    check("t2_nwe_cycles", 0, nwe_low[0] - s0, 2);
    check("t2_rsp_count", 0, rsp_cnt[0] - s1, 0);
    check("t2_nio_cycles", 0, nio_low[0] - s2, 4);
    check("t2_doe_cycles", 0, doe_high[0] - s3, 4);
    check("t2_idle_n_io", 0, o_nio[0], 1);
    check("t2_idle_data_oe", 0, o_doe[0], 0);
    check("t2_addr_kept", 0, o_addr[0], 24'h0000E1);
    check("t2_rsp_data_kept", 0, o_rd[0], 16'hA55A);

    // T3: four back-to-back commands
    s0 = nsel_low[0]; s1 = nsel_falls[0]; s2 = rsp_cnt[0];
    sfall_a.delete();
    send(0, mkc(24'h10000, 16'h0000, 1'b0, 1'b0), st);
    send(0, mkc(24'h00020, 16'h1234, 1'b1, 1'b0), st);
    send(0, mkc(24'h000C0, 16'h0000, 1'b0, 1'b1), st);
    send(0, mkc(24'h000C2, 16'hBEEF, 1'b1, 1'b1), st);
    wait_idle();
    check("t3_nsel_low_cycles", 0, nsel_low[0] - s0, 16);
    check("t3_nsel_falls", 0, nsel_falls[0] - s1, 1);
    check("t3_strobe_count", 0, sfall_a.size(), 4);
    for (int n = 1; n < sfall_a.size(); n++) check("t3_strobe_period", 0, sfall_a[n] - sfall_a[n-1], 4);
    check("t3_rsp_count", 0, rsp_cnt[0] - s2, 2);
    if (rlog_a.size() >= 2) begin
      check("t3_rsp0", 0, rlog_a[rlog_a.size()-2], 16'h5AAA);
      check("t3_rsp1", 0, rlog_a[rlog_a.size()-1], 16'h5A6A);
    end

    // T4: six commands into a depth-4 FIFO
    s0 = rsp_cnt[0]; s1 = noe_low[0]; s2 = nwe_low[0]; s3 = 0;
    send(0, mkc(24'h00101, 16'h0000, 1'b0, 1'b0), st); s3 += st;
    send(0, mkc(24'h00102, 16'h1111, 1'b1, 1'b0), st); s3 += st;
    send(0, mkc(24'h00103, 16'h0000, 1'b0, 1'b0), st); s3 += st;
    send(0, mkc(24'h00104, 16'h0000, 1'b0, 1'b0), st); s3 += st;
    send(0, mkc(24'h00105, 16'h2222, 1'b1, 1'b0), st); s3 += st;
    check("t4_stalls_first5", 0, s3, 0);
    send(0, mkc(24'h00106, 16'h0000, 1'b0, 1'b0), st);
    check("t4_stalls_sixth", 0, st, 1);
    wait_idle();
    check("t4_rsp_count", 0, rsp_cnt[0] - s0, 4);
    check("t4_noe_cycles", 0, noe_low[0] - s1, 8);
    check("t4_nwe_cycles", 0, nwe_low[0] - s2, 4);
    if (rlog_a.size() >= 4) begin
      check("t4_rsp0", 0, rlog_a[rlog_a.size()-4], 16'h5BAB);
      check("t4_rsp1", 0, rlog_a[rlog_a.size()-3], 16'h5BA9);
      check("t4_rsp2", 0, rlog_a[rlog_a.size()-2], 16'h5BAE);
      check("t4_rsp3", 0, rlog_a[rlog_a.size()-1], 16'h5BAC);
    end

    // T5: reset during the second STROBE cycle of a read
    s0 = rsp_cnt[0];
    send(0, mkc(24'h01234, 16'h0000, 1'b0, 1'b0), st);
    repeat (3) @(posedge clk);
    #1;
    check("t5_in_strobe", 0, o_noe[0], 0);
    rst = 1'b1;
    #1;
    check("t5_rst_n_oe", 0, o_noe[0], 1);
    check("t5_rst_n_sel", 0, o_nsel[0], 1);
    check("t5_rst_busy", 0, o_busy[0], 0);
    check("t5_rst_data_oe", 0, o_doe[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_rsp", 0, rsp_cnt[0] - s0, 0);
    send(0, mkc(24'h00100, 16'h0000, 1'b0, 1'b0), st);
    wait_idle();
    check("t5_rsp_after", 0, rsp_cnt[0] - s0, 1);
    if (rlog_a.size() >= 1) check("t5_rsp_data", 0, rlog_a[rlog_a.size()-1], 16'h5BAA);

    // T6: 2/3/2 instance with 24-bit address
    s0 = rsp_cnt[1]; s1 = noe_low[1]; s2 = nsel_low[1];
    send(1, mkc(24'hABCDEF, 16'h0000, 1'b0, 1'b0), st);
    wait_idle();
    check("t6_setup_len", 1, strobe_fall_cyc[1] - nsel_fall_cyc[1], 2);
    check("t6_strobe_len", 1, strobe_rise_cyc[1] - strobe_fall_cyc[1], 3);
    check("t6_hold_len", 1, nsel_rise_cyc[1] - strobe_rise_cyc[1], 2);
    check("t6_noe_cycles", 1, noe_low[1] - s1, 3);
    check("t6_nsel_cycles", 1, nsel_low[1] - s2, 7);
    check("t6_addr", 1, o_addr[1], 24'hABCDEF);
    check("t6_rsp_count", 1, rsp_cnt[1] - s0, 1);
    if (rlog_b.size() >= 1) check("t6_rsp_data", 1, rlog_b[rlog_b.size()-1], 16'h9745);
    s3 = nwe_low[1]; s4 = nsel_low[1];
    send(1, mkc(24'h123456, 16'h7E7E, 1'b1, 1'b0), st);
    wait_idle();
    check("t6_nwe_cycles", 1, nwe_low[1] - s3, 3);
    check("t6_wr_nsel_cycles", 1, nsel_low[1] - s4, 7);
    check("t6_wr_addr", 1, o_addr[1], 24'h123456);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/swan_bus_driver.md
Name: swan_bus_driver

Overview:
- Synthesizable, parametrised WonderSwan cartridge-bus cycle generator. It replaces hand-sequenced nSel/nOE/nWE/nIO stimulus in benches and drives the cartridge from on-board self-test logic.
- Commands (memory/IO, read/write) are queued in a FIFO. Each command is expanded into a SETUP/STROBE/HOLD bus cycle with programmable phase lengths.
- Read data is returned on a one-cycle response strobe.

Parameters:
ADDR_WIDTH, 20, width of Addr bus and CmdAddr
DATA_WIDTH, 16, width of data paths
SETUP_CYCLES, 1, clocks address/nIO/write data are stable before strobe (>=1)
STROBE_CYCLES, 2, clocks nOE or nWE held low (>=1)
HOLD_CYCLES, 1, clocks address/nIO/write data held after strobe release (>=1)
FIFO_DEPTH, 4, command FIFO entries, power of two >=2

Ports:
Clk  in  1  single clock; all state on rising edge
Reset  in  1  asynchronous, active-high reset
CmdValid  in  1  command offered
CmdReady  out  1  FIFO can accept (not full)
CmdAddr  in  ADDR_WIDTH  bus address
CmdData  in  DATA_WIDTH  write data (ignored for reads)
CmdWrite  in  1  1=write (nWE strobe), 0=read (nOE strobe)
CmdIO  in  1  1=IO cycle (nIO asserted), 0=memory cycle
RspValid  out  1  one-cycle pulse, read data valid
RspData  out  DATA_WIDTH  captured read data
Busy  out  1  FSM not IDLE or FIFO non-empty
nSel  out  1  cartridge select, active low
nOE  out  1  read strobe, active low
nWE  out  1  write strobe, active low
nIO  out  1  IO space select, active low
Addr  out  ADDR_WIDTH  bus address
DataOut  out  DATA_WIDTH  write data to bus
DataOE  out  1  1 = drive DataOut onto Data bus
DataIn  in  DATA_WIDTH  sampled bus data

Behaviour:
- Reset (async, any state): FIFO emptied, FSM=IDLE. Outputs: nSel=nOE=nWE=nIO=1, DataOE=0, Addr=0, DataOut=0, RspValid=0, RspData=0, Busy=0, CmdReady=0 while Reset high and 1 afterwards.
- FIFO: push on edge with CmdValid&&CmdReady. CmdReady=!full, using the registered count; no bypass, so a full FIFO refuses a push even when a pop occurs on the same edge. Simultaneous push+pop when non-empty leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, STROBE, HOLD. One phase down-counter, loaded on each state entry.
- IDLE: strobes high, DataOE=0, nSel=1. If FIFO non-empty, pop the head on the next edge, latch the command, and enter SETUP. An empty FIFO keeps the FSM in IDLE.
- SETUP (SETUP_CYCLES clocks): nSel=0. Addr=latched address. nIO=!CmdIO. For writes, DataOE=1 and DataOut=data. nOE=nWE=1.
- STROBE (STROBE_CYCLES clocks): outputs as in SETUP, plus nOE=0 (read) or nWE=0 (write).
- Read data capture: DataIn is registered on the edge leaving STROBE into RspData. RspValid=1 for exactly the first HOLD cycle. Writes never pulse RspValid; RspData keeps its last value.
- HOLD (HOLD_CYCLES clocks): nOE=nWE=1. Addr, nIO and DataOE/DataOut are unchanged. At the end of HOLD:
  - FIFO non-empty: pop and go directly to SETUP. nSel stays 0 and Addr/nIO switch on that edge.
  - FIFO empty: go to IDLE; nSel=1, nIO=1, DataOE=0. Addr keeps its last value.
- Latency: with the FIFO empty and FSM in IDLE, a command accepted on edge E0 enters SETUP at E1. Strobe falls at E1+SETUP_CYCLES. RspValid is high in the cycle after edge E1+SETUP_CYCLES+STROBE_CYCLES. Defaults: strobe low after E2–E4, RspValid after E4.
- Back-to-back bus-cycle period = SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES clocks, with no idle gap.
- nOE and nWE are never both low. A strobe is never low while Addr or nIO is changing.
- Reset asserted mid-STROBE releases the strobes and drops DataOE immediately (asynchronously). The interrupted command is discarded and RspValid is not pulsed.
- Busy = (state!=IDLE) || FIFO non-empty.

Test Plan:
- Defaults, memory read 0xFFF0, DataIn=0xA55A: nSel falls at E1; nOE low after E2..E4; nIO=1 throughout; RspValid one cycle after E4 with RspData=0xA55A; nSel=1 after E5.
- IO write addr 0x000E1, data 0x0002: nIO=0 and DataOE=1 with DataOut=0x0002 from SETUP through HOLD; nWE low 2 clocks; no RspValid; nIO back to 1 on IDLE entry.
- Four back-to-back commands (read, write, IO read, IO write): nSel held low continuously; strobe period exactly 4 clocks; two RspValid pulses in order with correct data.
- Push 6 commands while FSM busy with FIFO_DEPTH=4: CmdReady deasserts after 4 accepted; the remaining 2 are accepted only after pops; all 6 execute in order.
- Assert Reset during second STROBE cycle of a read: nOE=1 and nSel=1 before next edge; no RspValid; Busy=0; a new command after release executes normally.
- SETUP_CYCLES=2, STROBE_CYCLES=3, HOLD_CYCLES=2, ADDR_WIDTH=24: phase lengths 2/3/2 measured exactly; address 0xABCDEF appears on Addr unchanged.
